pic_udp_pack: RTL and testbench
===============================

# pic_udp_pack

Downstream consumer of the DRAM frame-read FIFO. It drains 32-bit pixel words from the read-side FIFO and slices each frame into fixed-size UDP payload packets. Each packet is one header word (frame number, line, X offset) followed by `PKT_WORDS` pixel words, delivered on a valid/ready/last stream to the UDP transmit core.

## Interface
Parameters:
- `WIDTH`, 1600: pixels per line; must be a multiple of `PKT_WORDS`.
- `HEIGHT`, 900: lines per frame.
- `PKT_WORDS`, 64: pixel words per packet; 1..2047.

Ports:
- `CLK` in 1: single clock for the whole block.
- `RST_N` in 1: asynchronous, active-low reset.
- `START` in 1: frame start level; a rising edge arms one frame.
- `fifo_dout` in 32: FIFO read data; valid 1 cycle after `fifo_rd_en` (standard FIFO, not FWFT).
- `fifo_rd_en` out 1: FIFO read strobe.
- `fifo_rd_cnt` in 12: FIFO occupancy in words.
- `tx_data` out 32: stream data.
- `tx_valid` out 1: stream valid.
- `tx_ready` in 1: stream ready from the UDP core.
- `tx_last` out 1: marks the final payload word of a packet.
- `tx_len` out 16: payload bytes per packet; constant (`PKT_WORDS`+1)*4.
- `busy` out 1: high from frame arm until the last packet is accepted.
- `frame_done` out 1: one-cycle pulse when the last word of a frame is accepted.

## Operation
- `START` passes through a 2-flop register; an edge is `{q1,q0}==2'b01`. Edges seen while `busy` is high are ignored.
- FSM states:
  - IDLE: on an edge, X=0, Y=0, go to WAIT_DATA, `busy`<=1.
  - WAIT_DATA: when `fifo_rd_cnt >= PKT_WORDS`, go to HDR. Evaluated every cycle; no timeout.
  - HDR: present header `{frame[7:0], Y[11:0], X[11:0]}` with `tx_last`=0. On `tx_valid&&tx_ready`, go to PAYLOAD.
  - PAYLOAD: stream `PKT_WORDS` FIFO words. On acceptance of the word with `tx_last`=1, go to NEXT.
  - NEXT: X += `PKT_WORDS`. If X reaches `WIDTH`, set X=0 and Y += 1.
    - If Y reaches `HEIGHT`: pulse `frame_done`, increment `frame` (8-bit, wraps 255->0), clear `busy`, go to IDLE.
    - Otherwise go to WAIT_DATA.
- FIFO reads feed a 2-entry output buffer:
  - Assert `fifo_rd_en` only in HDR/PAYLOAD, while issued reads are fewer than `PKT_WORDS` and buffered plus in-flight words are fewer than 2.
  - Never read more than `PKT_WORDS` words per packet.
  - Never read when `fifo_rd_cnt`==0; this case cannot occur after the WAIT_DATA check.
- The header is not placed in the FIFO buffer; it is muxed onto `tx_data` in HDR.
- `tx_data`/`tx_last` hold stable while `tx_valid`=1 and `tx_ready`=0 (AXI-stream rule). `tx_valid` never drops without a handshake.
- Arithmetic:
  - X and Y are 12-bit; `frame` is 8-bit.
  - Word counters are 11-bit, compared against `PKT_WORDS`.
- Asynchronous reset mid-packet aborts immediately: FSM to IDLE, all counters and the buffer cleared. The partially read FIFO is the upstream's concern (it is reset alongside).

## Timing
- Reset values: `fifo_rd_en`=0, `tx_valid`=0, `tx_data`=0, `tx_last`=0, `busy`=0, `frame_done`=0, `tx_len`=constant, `frame`=0.
- `START` edge to `busy`=1: 3 cycles (2 sync flops + FSM).
- WAIT_DATA condition true: header `tx_valid` in the next cycle.
- With `tx_ready` held high, a packet occupies exactly `PKT_WORDS`+1 consecutive valid cycles, with no bubbles. The first FIFO read issues in the first HDR cycle.
- Inter-packet gap: at least 2 cycles (NEXT, WAIT_DATA).
- `frame_done` asserts the cycle after the final handshake. `busy` falls in the same cycle.

## Structure
- Shared package `pic_pkg`: header field widths and positions (FRAME 31:24, Y 23:12, X 11:0), FSM state encoding, and the default `PKT_WORDS`, `WIDTH`, and `HEIGHT` constants shared with the read stage.
- One sub-module, `stream_skid2`: the 2-entry output buffer with valid/ready, reporting its occupancy to the read-credit logic.

## Test plan
Use `WIDTH`=128, `HEIGHT`=2, `PKT_WORDS`=64 and an FIFO model preloaded with an incrementing pattern 0..255.
- Pulse `START`, `tx_ready`=1:
  - 4 packets of 65 words each.
  - Headers 0x00000000, 0x00000040, 0x00001000, 0x00001040.
  - Payload 0..255 in order, `tx_last` on every 65th word.
  - One `frame_done` pulse; `frame`=1 afterwards.
- Randomized `tx_ready` (50%): identical data sequence, data stable while stalled, and the FIFO is never read past 64 words per packet.
- FIFO fills slowly, 1 word every 4 cycles: no header until `fifo_rd_cnt`>=64, and no underflow read.
- Second `START` edge mid-frame: ignored; `busy` stays high and the packet count stays 4.
- Assert `RST_N` low during the payload of packet 2: all outputs at reset values asynchronously, and a new `START` restarts with header 0x00000000 for `frame`=0.
- Run 256 frames: the header frame field wraps 0xFF->0x00.

Source files
------------

// File: rtl/pic_pkg.sv
// pic_pkg: definitions shared by the pixel read stage and the UDP packetiser.
//   - default frame geometry and packet size
//   - header word field positions (FRAME 31:24, Y 23:12, X 11:0)
//   - packetiser FSM state encoding
//   - pic_hdr(): assembles a header word from its fields
package pic_pkg;

   localparam int unsigned PIC_WIDTH     = 1600;
   localparam int unsigned PIC_HEIGHT    = 900;
   localparam int unsigned PIC_PKT_WORDS = 64;

   localparam int unsigned HDR_FRAME_LSB = 24;
   localparam int unsigned HDR_FRAME_W   = 8;
   localparam int unsigned HDR_Y_LSB     = 12;
   localparam int unsigned HDR_Y_W       = 12;
   localparam int unsigned HDR_X_LSB     = 0;
   localparam int unsigned HDR_X_W       = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_DATA,
      ST_HDR,
      ST_PAYLOAD,
      ST_NEXT
   } pic_state_e;

   function automatic logic [31:0] pic_hdr(input logic [HDR_FRAME_W-1:0] frame,
                                           input logic [HDR_Y_W-1:0]     y,
                                           input logic [HDR_X_W-1:0]     x);
      logic [31:0] h;
      h = '0;
      h[HDR_FRAME_LSB +: HDR_FRAME_W] = frame;
      h[HDR_Y_LSB     +: HDR_Y_W]     = y;
      h[HDR_X_LSB     +: HDR_X_W]     = x;
      return h;
   endfunction

endpackage

// File: rtl/stream_skid2.sv
// stream_skid2: 2-entry output buffer between a non-FWFT FIFO and a stream.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   in_valid_i/data_i: FIFO data returning one cycle after its read strobe
//   out_ready_i      : downstream ready
//   out_valid_o/data_o: buffered word (falls through when empty)
//   count_o          : words held, used by the caller's read-credit logic
// The caller never pushes while full, so there is no input ready.
module stream_skid2 (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        in_valid_i,
   input  logic [31:0] in_data_i,
   input  logic        out_ready_i,
   output logic        out_valid_o,
   output logic [31:0] out_data_o,
   output logic [1:0]  count_o
);

   logic [31:0] mem0_q, mem1_q;
   logic [1:0]  count_q;
   logic        push, pop;

   // Empty buffer passes returning FIFO data straight through so a packet
   // streams without bubbles.
   assign out_valid_o = (count_q != 2'd0) || in_valid_i;
   assign out_data_o  = (count_q != 2'd0) ? mem0_q : in_data_i;
   assign count_o     = count_q;
   assign push        = in_valid_i;
   assign pop         = out_valid_o && out_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem0_q  <= '0;
         mem1_q  <= '0;
         count_q <= '0;
      end else begin
         case (count_q)
            2'd0: begin
               if (push && !pop) begin
                  mem0_q  <= in_data_i;
                  count_q <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  mem0_q <= in_data_i;
               end else if (push) begin
                  mem1_q  <= in_data_i;
                  count_q <= 2'd2;
               end else if (pop) begin
                  count_q <= 2'd0;
               end
            end
            default: begin
               if (pop) begin
                  mem0_q <= mem1_q;
                  if (push) begin
                     mem1_q <= in_data_i;
                  end else begin
                     count_q <= 2'd1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/pic_udp_pack.sv
// pic_udp_pack: slices frames read from the DRAM read FIFO into UDP payload
// packets of one header word {frame, Y, X} plus PKT_WORDS pixel words.
//   CLK, RST_N      : clock, asynchronous active-low reset
//   START           : level; a rising edge arms one frame (ignored while busy)
//   fifo_dout/rd_en/rd_cnt : standard (non-FWFT) FIFO read side
//   tx_data/valid/ready/last/len : stream to the UDP transmit core
//   busy            : frame armed and not yet fully accepted
//   frame_done      : one-cycle pulse after the final word of a frame
module pic_udp_pack
   import pic_pkg::*;
#(
   parameter int unsigned WIDTH     = PIC_WIDTH,
   parameter int unsigned HEIGHT    = PIC_HEIGHT,
   parameter int unsigned PKT_WORDS = PIC_PKT_WORDS
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        START,
   input  logic [31:0] fifo_dout,
   output logic        fifo_rd_en,
   input  logic [11:0] fifo_rd_cnt,
   output logic [31:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        tx_last,
   output logic [15:0] tx_len,
   output logic        busy,
   output logic        frame_done
);

   localparam logic [10:0] PKT_W11  = 11'(PKT_WORDS);
   localparam logic [10:0] PKT_LAST = 11'(PKT_WORDS - 1);
   localparam logic [11:0] PKT_CNT  = 12'(PKT_WORDS);
   localparam logic [11:0] WIDTH_X  = 12'(WIDTH);
   localparam logic [11:0] HEIGHT_Y = 12'(HEIGHT);

   pic_state_e  state_q;
   logic [1:0]  start_q;
   logic [11:0] x_q, y_q, x_d, y_d;
   logic [7:0]  frame_q;
   logic        busy_q, frame_done_q;
   logic [10:0] rd_issued_q, sent_q;
   logic        inflight_q;
   logic        start_edge, in_stream, x_wrap, last_pkt;
   logic        buf_valid, buf_ready;
   logic [31:0] buf_data;
   logic [1:0]  buf_cnt;

   assign start_edge = (start_q == 2'b01) && !busy_q;
   assign in_stream  = (state_q == ST_HDR) || (state_q == ST_PAYLOAD);

   // Read credit: buffered words plus the one possibly in flight must fit
   // in the 2-entry buffer.
   assign fifo_rd_en = in_stream && (rd_issued_q < PKT_W11) &&
                       (({1'b0, buf_cnt} + {2'b00, inflight_q}) < 3'd2) &&
                       (fifo_rd_cnt != '0);

   assign tx_len     = 16'((PKT_WORDS + 1) * 4);
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

   always_comb begin
      x_d    = x_q + PKT_CNT;
      y_d    = y_q;
      x_wrap = (x_d == WIDTH_X);
      if (x_wrap) begin
         x_d = '0;
         y_d = y_q + 12'd1;
      end
      last_pkt = x_wrap && (y_d == HEIGHT_Y);
   end

   always_comb begin
      tx_valid  = 1'b0;
      tx_data   = '0;
      tx_last   = 1'b0;
      buf_ready = 1'b0;
      case (state_q)
         ST_HDR: begin
            tx_valid = 1'b1;
            tx_data  = pic_hdr(frame_q, y_q, x_q);
         end
         ST_PAYLOAD: begin
            tx_valid  = buf_valid;
            tx_data   = buf_data;
            tx_last   = buf_valid && (sent_q == PKT_LAST);
            buf_ready = tx_ready;
         end
         default: ;
      endcase
   end

   stream_skid2 u_skid (
      .clk_i       (CLK),
      .rst_ni      (RST_N),
      .in_valid_i  (inflight_q),
      .in_data_i   (fifo_dout),
      .out_ready_i (buf_ready),
      .out_valid_o (buf_valid),
      .out_data_o  (buf_data),
      .count_o     (buf_cnt)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= ST_IDLE;
         start_q      <= '0;
         x_q          <= '0;
         y_q          <= '0;
         frame_q      <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         rd_issued_q  <= '0;
         sent_q       <= '0;
         inflight_q   <= 1'b0;
      end else begin
         start_q      <= {start_q[0], START};
         inflight_q   <= fifo_rd_en;
         frame_done_q <= 1'b0;
         if (fifo_rd_en) begin
            rd_issued_q <= rd_issued_q + 11'd1;
         end
         case (state_q)
            ST_IDLE: begin
               if (start_edge) begin
                  x_q     <= '0;
                  y_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_WAIT_DATA;
               end
            end
            ST_WAIT_DATA: begin
               if (fifo_rd_cnt >= PKT_CNT) begin
                  rd_issued_q <= '0;
                  sent_q      <= '0;
                  state_q     <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (tx_ready) begin
                  state_q <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (tx_valid && tx_ready) begin
                  sent_q <= sent_q + 11'd1;
                  if (tx_last) begin
                     state_q <= ST_NEXT;
                     // Frame completion is flagged at the final handshake so
                     // frame_done/busy change in the cycle right after it.
                     if (last_pkt) begin
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                     end
                  end
               end
            end
            ST_NEXT: begin
               x_q <= x_d;
               y_q <= y_d;
               if (last_pkt) begin
                  frame_q <= frame_q + 8'd1;
                  state_q <= ST_IDLE;
               end else begin
                  state_q <= ST_WAIT_DATA;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pic_udp_pack.sv
// tb_pic_udp_pack: randomized self-checking bench for pic_udp_pack with a
// queue-based FIFO model and an expected-stream queue built from frame
// geometry (headers per packet, incrementing payload).
module tb_pic_udp_pack;

   localparam int unsigned W  = 128;
   localparam int unsigned H  = 2;
   localparam int unsigned PK = 64;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        START = 1'b0;
   logic [31:0] fifo_dout = '0;
   logic        fifo_rd_en;
   logic [11:0] fifo_rd_cnt = '0;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        tx_last;
   logic [15:0] tx_len;
   logic        busy;
   logic        frame_done;

   always #5 CLK = ~CLK;

   pic_udp_pack #(.WIDTH(W), .HEIGHT(H), .PKT_WORDS(PK)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .START       (START),
      .fifo_dout   (fifo_dout),
      .fifo_rd_en  (fifo_rd_en),
      .fifo_rd_cnt (fifo_rd_cnt),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_last     (tx_last),
      .tx_len      (tx_len),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- FIFO model ----------------
   logic [31:0] fifo_q[$];
   int unsigned fill_mode = 0;
   int unsigned flush_gen = 0, flush_seen = 0;
   int unsigned fill_pushed = 0, fill_tick = 0;
   logic [31:0] fill_next = '0;
   int unsigned rd_total = 0, rd_pkt = 0;

   always @(posedge CLK) begin
      if (fifo_rd_en) begin
         rd_total++;
         rd_pkt++;
         check("rd_per_pkt", 32'(rd_pkt <= PK), 32'd1);
         if (fifo_q.size() == 0) check("underflow", 32'd0, 32'd1);
         else fifo_dout <= fifo_q.pop_front();
      end
      if (flush_gen != flush_seen) begin
         flush_seen  = flush_gen;
         fifo_q.delete();
         fill_next   = '0;
         fill_pushed = 0;
         fill_tick   = 0;
      end
      case (fill_mode)
         1: while (fill_pushed < 256) begin
               fifo_q.push_back(fill_next); fill_next++; fill_pushed++;
            end
         2: begin
               fill_tick++;
               if ((fill_tick % 4 == 0) && fill_pushed < 256) begin
                  fifo_q.push_back(fill_next); fill_next++; fill_pushed++;
               end
            end
         3: if (fifo_q.size() < 200) begin
               fifo_q.push_back(fill_next); fill_next++;
            end
         default: ;
      endcase
      fifo_rd_cnt <= 12'(fifo_q.size());
   end

   // ---------------- ready driver ----------------
   bit rnd_ready = 0;
   initial forever begin
      @(posedge CLK);
      #1;
      tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // ---------------- expected stream ----------------
   typedef struct packed {
      logic [31:0] d;
      logic        last;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] pay_next = '0;

   task automatic build_frame(input logic [7:0] fr);
      for (int unsigned y = 0; y < H; y++) begin
         for (int unsigned x = 0; x < W; x += PK) begin
            exp_q.push_back({fr, 12'(y), 12'(x), 1'b0});
            for (int unsigned k = 0; k < PK; k++) begin
               exp_q.push_back({pay_next, (k == PK - 1)});
               pay_next++;
            end
         end
      end
   endtask

   // ---------------- monitor ----------------
   int unsigned fd_cnt = 0, acc_words = 0, run_len = 0;
   bit          prev_valid = 0, stalled = 0, check_runs = 0;
   logic [31:0] held_d = '0;
   logic        held_l = 1'b0;
   exp_t        e;

   always @(negedge CLK) begin
      if (stalled) begin
         check("stall_valid", 32'(tx_valid), 32'd1);
         check("stall_data", tx_data, held_d);
         check("stall_last", 32'(tx_last), 32'(held_l));
      end
      stalled = tx_valid && !tx_ready;
      held_d  = tx_data;
      held_l  = tx_last;
      if (tx_valid && !prev_valid) begin
         rd_pkt = 0;
         check("hdr_fifo_cnt", 32'(fifo_q.size() >= PK), 32'd1);
      end
      if (tx_valid && tx_ready) begin
         if (exp_q.size() == 0) check("extra_word", 32'd1, 32'd0);
         else begin
            e = exp_q.pop_front();
            check("tx_data", tx_data, e.d);
            check("tx_last", 32'(tx_last), 32'(e.last));
         end
         acc_words++;
      end
      if (frame_done) fd_cnt++;
      if (tx_valid) run_len++;
      else begin
         if (check_runs && run_len != 0) check("pkt_run_len", 32'(run_len), 32'(PK + 1));
         run_len = 0;
      end
      prev_valid = tx_valid;
   end

   // ---------------- sequences ----------------
   task automatic check_reset_outputs();
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", tx_data, 32'd0);
      check("rst_tx_last", 32'(tx_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_tx_len", 32'(tx_len), 32'((PK + 1) * 4));
   endtask

   task automatic run_frame(input bit restrike);
      int unsigned fd0, rd0, w0, t;
      fd0 = fd_cnt; rd0 = rd_total; w0 = acc_words;
      START = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("busy_rise", 32'(busy), 32'd1);
      START = 1'b0;
      if (restrike) begin
         repeat (40) @(posedge CLK);
         #1 START = 1'b1;
         repeat (3) @(posedge CLK);
         #1 START = 1'b0;
         check("busy_restrike", 32'(busy), 32'd1);
      end
      t = 0;
      while (fd_cnt == fd0 && t < 20000) begin
         @(posedge CLK);
         t++;
      end
      check("frame_timeout", 32'(t < 20000), 32'd1);
      repeat (4) @(posedge CLK);
      #1;
      check("frame_done_pulses", 32'(fd_cnt - fd0), 32'd1);
      check("busy_after", 32'(busy), 32'd0);
      check("words", 32'(acc_words - w0), 32'(4 * (PK + 1)));
      check("reads", 32'(rd_total - rd0), 32'(4 * PK));
      check("exp_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int unsigned w0, t;
      repeat (3) @(posedge CLK);
      #1;
      check_reset_outputs();
      RST_N = 1'b1;

      // preloaded FIFO, ready high, a second START edge mid-frame
      flush_gen++; fill_mode = 1; pay_next = '0; build_frame(8'd0);
      check_runs = 1;
      repeat (2) @(posedge CLK);
      #1 run_frame(1'b1);

      // randomized ready
      flush_gen++; fill_mode = 1; pay_next = '0; build_frame(8'd1);
      check_runs = 0; rnd_ready = 1;
      repeat (2) @(posedge CLK);
      #1 run_frame(1'b0);
      rnd_ready = 0;

      // slow FIFO fill
      flush_gen++; fill_mode = 2; pay_next = '0; build_frame(8'd2);
      check_runs = 1;
      repeat (2) @(posedge CLK);
      #1 run_frame(1'b0);

      // asynchronous reset during packet 2 payload
      flush_gen++; fill_mode = 1; pay_next = '0; build_frame(8'd3);
      check_runs = 0;
      repeat (2) @(posedge CLK);
      #1;
      w0 = acc_words;
      START = 1'b1;
      t = 0;
      while ((acc_words - w0) < (PK + 1 + 20) && t < 2000) begin
         @(posedge CLK);
         t++;
      end
      check("abort_timeout", 32'(t < 2000), 32'd1);
      #3 RST_N = 1'b0;
      #1;
      check_reset_outputs();
      START = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge CLK);
      #1 RST_N = 1'b1;
      flush_gen++; fill_mode = 1; pay_next = '0; build_frame(8'd0);
      check_runs = 1;
      repeat (2) @(posedge CLK);
      #1 run_frame(1'b0);

      // 256 frames with continuous refill; header frame field wraps to 0
      flush_gen++; fill_mode = 3; pay_next = '0;
      for (int unsigned f = 1; f <= 256; f++) begin
         build_frame(8'(f));
         run_frame(1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
